// File: rtl/irq_pkg.sv
// irq_pkg: shared interrupt types and default sizes for requester and controller.
//   REQ_IDLE/REQ_ASSERT/REQ_GAP  requester FSM encoding (fixed 2-bit, legacy-compatible)
//   IRQ_N_SRC, IRQ_CNT_W         default source count and coalescing counter width
package irq_pkg;
  localparam int IRQ_N_SRC = 4;
  localparam int IRQ_CNT_W = 4;
  typedef enum logic [1:0] {
    REQ_IDLE   = 2'd0,
    REQ_ASSERT = 2'd1,
    REQ_GAP    = 2'd2
  } irq_req_state_t;
endpackage

// File: rtl/irq_evt_counter.sv
// irq_evt_counter: saturating event counter with sticky overflow and increment-on-clear.
//   clk, rst_n   clock, async active-low reset
//   inc_i        count one event this cycle
//   clr_i        clear count and overflow (a same-cycle inc_i leaves the count at 1)
//   cnt_o        registered count
//   cnt_nxt_o    value cnt_o takes after the next edge
//   ovf_o        sticky flag: an event arrived while the count was saturated
module irq_evt_counter
  import irq_pkg::*;
#(
  parameter int CNT_W = IRQ_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             ovf_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, sat;
  assign sat = &cnt_q;
  always_comb begin
    cnt_d = clr_i ? CNT_W'(inc_i) : cnt_q + CNT_W'(inc_i & ~sat);
    ovf_d = ~clr_i & (ovf_q | (inc_i & sat));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_d;
  assign ovf_o     = ovf_q;
endmodule

// File: rtl/irq_requester.sv
// irq_requester: coalesces event strobes and presents one prioritised request to the irq controller.
//   clk, rst_n   clock, async active-low reset
//   evt_i        per-source event strobes (index 0 = highest priority)
//   irq_en_i     per-source enable mask
//   ack_i        controller acknowledge, ack_id_i is the acknowledged source
//   irq_o        registered request level; irq_id_o/irq_cnt_o describe it (0 while low)
//   pending_o    per-source nonzero count, independent of enable
//   overflow_o   sticky per-source saturation flag
//   err_o        one-cycle pulse on an ack that does not match the presented source
module irq_requester
  import irq_pkg::*;
#(
  parameter int N_SRC = IRQ_N_SRC,
  parameter int CNT_W = IRQ_CNT_W,
  parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] evt_i,
  input  logic [N_SRC-1:0] irq_en_i,
  input  logic             ack_i,
  input  logic [ID_W-1:0]  ack_id_i,
  output logic             irq_o,
  output logic [ID_W-1:0]  irq_id_o,
  output logic [CNT_W-1:0] irq_cnt_o,
  output logic [N_SRC-1:0] pending_o,
  output logic [N_SRC-1:0] overflow_o,
  output logic             err_o
);
  irq_req_state_t   state_q, state_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d, sel;
  logic [CNT_W-1:0] cnt [N_SRC];
  logic [CNT_W-1:0] cnt_nxt [N_SRC];
  logic [N_SRC-1:0] clr, req;
  logic             ack_ok, hit;
  logic             irq_q;
  logic [ID_W-1:0]  irq_id_q;
  logic [CNT_W-1:0] irq_cnt_q;
  logic             err_q;
  assign ack_ok = ack_i && state_q == REQ_ASSERT && ack_id_i == cur_id_q;
  for (genvar g = 0; g < N_SRC; g++) begin : g_cnt
    assign clr[g]       = ack_ok && cur_id_q == ID_W'(g);
    assign pending_o[g] = |cnt[g];
    irq_evt_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_i     (evt_i[g]),
      .clr_i     (clr[g]),
      .cnt_o     (cnt[g]),
      .cnt_nxt_o (cnt_nxt[g]),
      .ovf_o     (overflow_o[g])
    );
  end
  assign req = pending_o & irq_en_i;
  // Descending scan so the lowest set index is the one left in sel.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit = 1'b1;
        sel = ID_W'(i);
      end
    end
  end
  // A valid ack wins over a same-cycle enable drop; REQ_GAP always lasts one cycle.
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    case (state_q)
      REQ_IDLE: begin
        state_d  = hit ? REQ_ASSERT : REQ_IDLE;
        cur_id_d = hit ? sel : cur_id_q;
      end
      REQ_ASSERT: state_d = ack_ok ? REQ_GAP : (irq_en_i[cur_id_q] ? REQ_ASSERT : REQ_IDLE);
      default:    state_d = REQ_IDLE;
    endcase
  end
  // Outputs are registered from next-state values so they line up with the state flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= REQ_IDLE;
      cur_id_q  <= '0;
      irq_q     <= 1'b0;
      irq_id_q  <= '0;
      irq_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      irq_q     <= state_d == REQ_ASSERT;
      irq_id_q  <= state_d == REQ_ASSERT ? cur_id_d : '0;
      irq_cnt_q <= state_d == REQ_ASSERT ? cnt_nxt[cur_id_d] : '0;
      err_q     <= ack_i & ~ack_ok;
    end
  end
  assign irq_o     = irq_q;
  assign irq_id_o  = irq_id_q;
  assign irq_cnt_o = irq_cnt_q;
  assign err_o     = err_q;
endmodule

// File: tb/tb_irq_requester.sv
// tb_irq_requester: directed and random checks of irq_requester against a behavioural model.
module tb_irq_requester;
  localparam int N = 4;
  localparam int CW = 4;
  localparam int IW = 2;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] evt = '0;
  logic [N-1:0] en = '0;
  logic ack = 1'b0;
  logic [IW-1:0] ack_id = '0;
  logic irq_o, err_o;
  logic [IW-1:0] irq_id_o;
  logic [CW-1:0] irq_cnt_o;
  logic [N-1:0] pending_o, overflow_o;
  int n_chk = 0;
  int n_fail = 0;
  int m_cnt [N];
  bit m_ovf [N];
  bit m_up, m_gap, m_err;
  int m_id;
  irq_requester #(.N_SRC(N), .CNT_W(CW), .ID_W(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .evt_i      (evt),
    .irq_en_i   (en),
    .ack_i      (ack),
    .ack_id_i   (ack_id),
    .irq_o      (irq_o),
    .irq_id_o   (irq_id_o),
    .irq_cnt_o  (irq_cnt_o),
    .pending_o  (pending_o),
    .overflow_o (overflow_o),
    .err_o      (err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 0;
    end
    m_up = 0;
    m_gap = 0;
    m_err = 0;
    m_id = 0;
  endtask
  // Request semantics: one presented source, cleared by a matching ack, one idle cycle after each ack.
  task automatic model_update(input logic [N-1:0] e, input logic [N-1:0] f, input logic a, input logic [IW-1:0] id);
    bit valid;
    int first;
    valid = a && m_up && int'(id) == m_id;
    first = -1;
    for (int i = 0; i < N; i++) if (first < 0 && m_cnt[i] != 0 && f[i]) first = i;
    m_err = a && !valid;
    for (int i = 0; i < N; i++) begin
      if (valid && i == m_id) begin
        m_cnt[i] = e[i] ? 1 : 0;
        m_ovf[i] = 0;
      end else if (e[i]) begin
        if (m_cnt[i] == MAXC) m_ovf[i] = 1;
        else m_cnt[i]++;
      end
    end
    if (m_up) begin
      if (valid) begin
        m_up = 0;
        m_gap = 1;
      end else if (!f[m_id]) m_up = 0;
    end else if (m_gap) m_gap = 0;
    else if (first >= 0) begin
      m_up = 1;
      m_id = first;
    end
  endtask
  task automatic check_all();
    logic [N-1:0] p, o;
    for (int i = 0; i < N; i++) begin
      p[i] = m_cnt[i] != 0;
      o[i] = m_ovf[i];
    end
    chk("irq", 32'(irq_o), 32'(m_up));
    chk("irq_id", 32'(irq_id_o), m_up ? m_id : 0);
    chk("irq_cnt", 32'(irq_cnt_o), m_up ? m_cnt[m_id] : 0);
    chk("pending", 32'(pending_o), 32'(p));
    chk("overflow", 32'(overflow_o), 32'(o));
    chk("err", 32'(err_o), 32'(m_err));
  endtask
  task automatic step(input logic [N-1:0] e, input logic [N-1:0] f, input logic a, input logic [IW-1:0] id);
    evt = e;
    en = f;
    ack = a;
    ack_id = id;
    model_update(e, f, a, id);
    @(posedge clk);
    #1;
    check_all();
    evt = '0;
    ack = 1'b0;
  endtask
  initial begin
    logic [N-1:0] e, f;
    logic a;
    logic [IW-1:0] id;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    // single event
    step(4'b0100, 4'hF, 0, 0);
    chk("single_lat1", 32'(irq_o), 0);
    step(4'b0000, 4'hF, 0, 0);
    chk("single_irq", 32'(irq_o), 1);
    chk("single_id", 32'(irq_id_o), 2);
    chk("single_cnt", 32'(irq_cnt_o), 1);
    step(4'b0000, 4'hF, 1, 2);
    chk("single_ack_irq", 32'(irq_o), 0);
    chk("single_ack_pend", 32'(pending_o), 0);
    step(4'b0000, 4'hF, 0, 0);
    chk("single_gap", 32'(irq_o), 0);
    // priority
    step(4'b1010, 4'hF, 0, 0);
    step(4'b0000, 4'hF, 0, 0);
    chk("prio_first", 32'(irq_id_o), 1);
    step(4'b0000, 4'hF, 1, 1);
    step(4'b0000, 4'hF, 0, 0);
    chk("prio_gap", 32'(irq_o), 0);
    step(4'b0000, 4'hF, 0, 0);
    chk("prio_second_id", 32'(irq_id_o), 3);
    chk("prio_second_cnt", 32'(irq_cnt_o), 1);
    step(4'b0000, 4'hF, 1, 3);
    step(4'b0000, 4'hF, 0, 0);
    // saturation with source disabled
    for (int i = 0; i < 20; i++) step(4'b0001, 4'h0, 0, 0);
    chk("sat_pend", 32'(pending_o[0]), 1);
    chk("sat_irq", 32'(irq_o), 0);
    chk("sat_ovf", 32'(overflow_o[0]), 1);
    step(4'b0000, 4'hF, 0, 0);
    chk("sat_id", 32'(irq_id_o), 0);
    chk("sat_cnt", 32'(irq_cnt_o), 15);
    step(4'b0000, 4'hF, 1, 0);
    chk("sat_ovf_clr", 32'(overflow_o[0]), 0);
    step(4'b0000, 4'hF, 0, 0);
    step(4'b0000, 4'hF, 0, 0);
    // ack/event collision
    step(4'b0001, 4'hF, 0, 0);
    step(4'b0000, 4'hF, 0, 0);
    step(4'b0001, 4'hF, 1, 0);
    chk("coll_irq0", 32'(irq_o), 0);
    step(4'b0000, 4'hF, 0, 0);
    chk("coll_irq1", 32'(irq_o), 0);
    step(4'b0000, 4'hF, 0, 0);
    chk("coll_reassert", 32'(irq_o), 1);
    chk("coll_cnt", 32'(irq_cnt_o), 1);
    step(4'b0000, 4'hF, 1, 0);
    step(4'b0000, 4'hF, 0, 0);
    // protocol errors
    step(4'b0010, 4'hF, 0, 0);
    step(4'b0000, 4'hF, 0, 0);
    step(4'b0000, 4'hF, 1, 3);
    chk("err_bad_id", 32'(err_o), 1);
    chk("err_irq_held", 32'(irq_o), 1);
    chk("err_cnt_held", 32'(irq_cnt_o), 1);
    step(4'b0000, 4'hF, 0, 0);
    chk("err_one_cycle", 32'(err_o), 0);
    step(4'b0000, 4'hF, 1, 1);
    step(4'b0000, 4'hF, 0, 0);
    step(4'b0000, 4'hF, 1, 0);
    chk("err_idle", 32'(err_o), 1);
    // withdraw and re-enable
    step(4'b0100, 4'hF, 0, 0);
    step(4'b0100, 4'hF, 0, 0);
    step(4'b0000, 4'hF, 0, 0);
    step(4'b0000, 4'hB, 0, 0);
    chk("wd_irq", 32'(irq_o), 0);
    chk("wd_pend", 32'(pending_o[2]), 1);
    step(4'b0000, 4'hF, 0, 0);
    chk("wd_reassert_id", 32'(irq_id_o), 2);
    chk("wd_reassert_cnt", 32'(irq_cnt_o), 2);
    // reset mid-assert
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    // random traffic
    for (int c = 0; c < 600; c++) begin
      e = N'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      f = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : 4'hF;
      a = 1'b0;
      id = '0;
      if (m_up && $urandom_range(0, 2) == 0) begin
        a = 1'b1;
        id = IW'(m_id);
      end else if ($urandom_range(0, 19) == 0) begin
        a = 1'b1;
        id = IW'($urandom_range(0, 3));
      end
      step(e, f, a, id);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_requester.md
# irq_requester

Peripheral-side interrupt source that feeds the interrupt controller's single-line `irq` input.
- Coalesces per-source event strobes into saturating counters.
- Presents the highest-priority enabled pending source on a registered `irq_o` level with ID and count.
- Holds the request until the controller acknowledges it with a matching ID, then clears that source.
- Sits between peripheral event logic and the controller's pending/servicing state machine.

## Interface
- `N_SRC`, default 4: number of event sources (index 0 = highest priority).
- `CNT_W`, default 4: per-source coalescing counter width.
- `ID_W`, default `$clog2(N_SRC)`: source ID width.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `evt_i`  in  N_SRC  one-cycle event strobes; one count per set bit per cycle.
- `irq_en_i`  in  N_SRC  per-source enable mask, 1 = may raise `irq_o`.
- `ack_i`  in  1  controller acknowledge strobe.
- `ack_id_i`  in  ID_W  ID being acknowledged, sampled with `ack_i`.
- `irq_o`  out  1  registered interrupt request level.
- `irq_id_o`  out  ID_W  ID of the presented source; valid while `irq_o`=1.
- `irq_cnt_o`  out  CNT_W  live count of the presented source.
- `pending_o`  out  N_SRC  per-source count != 0, regardless of enable.
- `overflow_o`  out  N_SRC  sticky per-source saturation flag.
- `err_o`  out  1  one-cycle protocol-error pulse.

## Operation
- Counters
  - `evt_i[i]`=1: `cnt[i]` increments.
  - At `2^CNT_W-1`, `cnt[i]` holds and `overflow_o[i]` sets (sticky).
  - Disabled sources still count.
- FSM states: `REQ_IDLE`, `REQ_ASSERT`, `REQ_GAP`.
- `REQ_IDLE`
  - `irq_o`=0.
  - If `pending & irq_en_i` is nonzero: latch the lowest set index into `cur_id`, go to `REQ_ASSERT`.
- `REQ_ASSERT`
  - `irq_o`=1, `irq_id_o`=`cur_id`, `irq_cnt_o`=`cnt[cur_id]` (live, may grow).
  - `cur_id` stays fixed even if a higher-priority source becomes pending.
  - `ack_i`=1 with `ack_id_i`==`cur_id`: clear `cnt[cur_id]` and `overflow_o[cur_id]`, go to `REQ_GAP`.
  - If `evt_i[cur_id]`=1 in the same cycle as that ack, the count becomes 1, not 0.
  - `ack_i`=1 with a mismatched ID: `err_o` pulses; state, counts and flags are unchanged.
  - `irq_en_i[cur_id]` drops with no valid ack: withdraw to `REQ_IDLE`; the count is retained.
  - A valid ack takes precedence over a same-cycle enable drop.
- `REQ_GAP`
  - `irq_o`=0 for exactly one cycle, then `REQ_IDLE`.
  - Guarantees the controller sees an edge between back-to-back requests.
- `ack_i`=1 in `REQ_IDLE` or `REQ_GAP`: `err_o` pulses, ack ignored.
- `irq_id_o` and `irq_cnt_o` read 0 when `irq_o`=0.

## Timing
- Reset (async, immediate):
  - State `REQ_IDLE`.
  - All counters and `cur_id` 0.
  - Outputs `irq_o`=0, `irq_id_o`=0, `irq_cnt_o`=0, `pending_o`=0, `overflow_o`=0, `err_o`=0.
- Reset mid-`REQ_ASSERT` drops `irq_o` immediately and discards all counts.
- Event sampled at edge k:
  - `cnt`/`pending_o` update after edge k.
  - FSM enters `REQ_ASSERT` at edge k+1, so `irq_o`=1 after edge k+1 (2-cycle latency).
- Valid ack sampled at edge a:
  - `irq_o`=0 after edge a (`REQ_GAP`), `REQ_IDLE` after edge a+1.
  - Earliest re-assert is after edge a+2, so `irq_o` is low for at least 2 cycles.
- Enable drop sampled at edge e: `irq_o`=0 after edge e.
- `err_o` is registered: high for the single cycle after the offending sample edge.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package `irq_pkg`:
  - `irq_req_state_t` enum (`REQ_IDLE`, `REQ_ASSERT`, `REQ_GAP`).
  - Default `N_SRC`/`CNT_W` localparams, shared with the controller.
- Sub-module `irq_evt_counter`:
  - Saturating counter with sticky overflow, clear input and same-cycle increment-on-clear.
  - Instantiated `N_SRC` times via generate.
- Top level holds the priority encoder, FSM, ack checking and output registers.

## Test plan
- Single event: `evt_i`=4'b0100 for 1 cycle, all enabled → `irq_o`=1 two cycles later, `irq_id_o`=2, `irq_cnt_o`=1. Then ack id 2 → `irq_o`=0 next cycle, `pending_o`=0, `irq_o` low ≥2 cycles.
- Priority: `evt_i`=4'b1010 in one cycle → id 1 first. After ack, gap, then id 3 with cnt 1; never id 3 while id 1 is pending.
- Saturation:
  - 20 strobes on src0 with `irq_en_i`=0 → `pending_o[0]`=1, `irq_o`=0, `overflow_o[0]`=1.
  - Enable src0 → `irq_o` with id 0, cnt 15.
  - Ack → `overflow_o[0]`=0.
- Ack/event collision: `evt_i[0]` in the same cycle as ack id 0 → cnt=1, `irq_o` re-asserts exactly 2 cycles after the ack.
- Protocol errors:
  - Ack id 3 while presenting id 1 → `err_o` pulse, `irq_o` stays 1, cnt unchanged.
  - Ack while idle → `err_o` pulse only.
- Withdraw/reset:
  - Clear `irq_en_i[cur_id]` while asserted → `irq_o` low next cycle, count retained; re-enable → re-assert with same count.
  - `rst_n` low mid-assert → all outputs 0 immediately.
